ah_mul_pipelined: RTL and testbench

- Fully pipelined signed WIDTH x WIDTH multiplier. It is the inverse-operation companion to the pipelined divider.
- Uses the same start / data_valid pipeline handshake, so the datapath can reconstruct dividends (quotient*divisor) or scale operands.
- Accepts one operand pair per cycle and returns a full 2*WIDTH signed product plus an overflow flag after a fixed latency.

---
 rtl/ah_arith_pkg.sv | 28 ++
 rtl/ah_mul_stage.sv | 40 ++++
 rtl/ah_mul_pipelined.sv | 117 +++++++++++
 tb/tb_ah_mul_pipelined.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ah_arith_pkg.sv
// Shared arithmetic definitions for the pipelined multiplier and divider.
package ah_arith_pkg;

  localparam int unsigned AH_WIDTH  = 64;
  localparam int unsigned AH_STAGES = 8;
  localparam int unsigned AH_BPS    = AH_WIDTH / AH_STAGES;

  // One operation in flight: everything a stage needs travels together.
  typedef struct packed {
    logic                    valid;
    logic                    neg;
    logic [AH_WIDTH-1:0]     abs_a;
    logic [AH_WIDTH-1:0]     b_rem;
    logic [2*AH_WIDTH-1:0]   acc;
  } mul_stage_t;

  // Magnitude of a two's complement operand; -2^(W-1) maps to 2^(W-1) unsigned.
  function automatic logic [AH_WIDTH-1:0] ah_abs(input logic [AH_WIDTH-1:0] x);
    return x[AH_WIDTH-1] ? (~x + AH_WIDTH'(1)) : x;
  endfunction

  // Conditional two's complement negate of a double-width value.
  function automatic logic [2*AH_WIDTH-1:0] ah_cond_neg(input logic                  neg,
                                                        input logic [2*AH_WIDTH-1:0] x);
    return neg ? (~x + (2*AH_WIDTH)'(1)) : x;
  endfunction

endpackage

// File: rtl/ah_mul_stage.sv
// One partial-product accumulation stage: adds |A| * (low BPS bits of the
// remaining |B|) shifted by SHIFT, and retires those multiplier bits.
module ah_mul_stage
  import ah_arith_pkg::*;
#(
  parameter int unsigned BPS   = AH_BPS,
  parameter int unsigned SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  mul_stage_t in_rec,
  output mul_stage_t out_rec
);

  localparam int unsigned W  = AH_WIDTH;
  localparam int unsigned PW = W + BPS;

  logic [BPS-1:0] slice;
  logic [PW-1:0]  pp;
  mul_stage_t     rec_d;
  mul_stage_t     rec_q;

  // Narrow W x BPS partial product, then align and accumulate.
  always_comb begin
    rec_d       = in_rec;
    slice       = in_rec.b_rem[BPS-1:0];
    pp          = PW'(in_rec.abs_a) * PW'(slice);
    rec_d.b_rem = in_rec.b_rem >> BPS;
    rec_d.acc   = in_rec.acc + ((2*W)'(pp) << SHIFT);
  end

  // Stage register; data advances every cycle, valid marks real operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rec_q <= '0;
    else        rec_q <= rec_d;
  end

  assign out_rec = rec_q;

endmodule

// File: rtl/ah_mul_pipelined.sv
// Fully pipelined signed multiplier: magnitude/sign split on input, STAGES
// accumulation stages, then sign restore and overflow detection.
// The stage record is sized from the package constants, so WIDTH/STAGES
// overrides must be matched there.
module ah_mul_pipelined
  import ah_arith_pkg::*;
#(
  parameter int unsigned WIDTH  = AH_WIDTH,
  parameter int unsigned STAGES = AH_STAGES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               data_valid,
  output logic [2*WIDTH-1:0] product,
  output logic               overflow
);

  localparam int unsigned BPS = WIDTH / STAGES;

  mul_stage_t         s0_d;
  mul_stage_t         s0_q;
  mul_stage_t         stg [0:STAGES];

  logic [2*WIDTH-1:0] sgn_d;
  logic [2*WIDTH-1:0] sgn_q;
  logic               sval_d;
  logic               sval_q;

  logic [2*WIDTH-1:0] product_d;
  logic [2*WIDTH-1:0] product_q;
  logic               overflow_d;
  logic               overflow_q;
  logic               data_valid_d;
  logic               data_valid_q;
  logic [WIDTH:0]     top_bits;

  // Input stage: split operands into sign and magnitudes.
  always_comb begin
    s0_d       = '0;
    s0_d.valid = start;
    s0_d.neg   = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
    s0_d.abs_a = ah_abs(multiplicand);
    s0_d.b_rem = ah_abs(multiplier);
    s0_d.acc   = '0;
  end

  // Input stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s0_q <= '0;
    else        s0_q <= s0_d;
  end

  assign stg[0] = s0_q;

  // Accumulation chain; stage k consumes multiplier bits [k*BPS-1:(k-1)*BPS].
  for (genvar k = 1; k <= int'(STAGES); k++) begin : g_stage
    ah_mul_stage #(
      .BPS   (BPS),
      .SHIFT ((k - 1) * BPS)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_rec  (stg[k-1]),
      .out_rec (stg[k])
    );
  end

  // Sign restore; zero magnitude negates to zero.
  always_comb begin
    sgn_d  = ah_cond_neg(stg[STAGES].neg, stg[STAGES].acc);
    sval_d = stg[STAGES].valid;
  end

  // Signed-product register, splitting negate and overflow across two cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_q  <= '0;
      sval_q <= 1'b0;
    end else begin
      sgn_q  <= sgn_d;
      sval_q <= sval_d;
    end
  end

  // Overflow when the upper W+1 bits are not a pure sign extension; hold outputs between results.
  always_comb begin
    product_d    = product_q;
    overflow_d   = overflow_q;
    data_valid_d = sval_q;
    top_bits     = sgn_q[2*WIDTH-1:WIDTH-1];
    if (sval_q) begin
      product_d  = sgn_q;
      overflow_d = (|top_bits) & ~(&top_bits);
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_q    <= '0;
      overflow_q   <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      product_q    <= product_d;
      overflow_q   <= overflow_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign product    = product_q;
  assign overflow   = overflow_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_ah_mul_pipelined.sv
// Scoreboard bench for ah_mul_pipelined: the driver queues expected results,
// the monitor pops and checks them (value, overflow, latency) on data_valid.
module tb_ah_mul_pipelined;

  localparam int unsigned W   = 64;
  localparam int unsigned LAT = 10;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           data_valid;
  logic [2*W-1:0] product;
  logic           overflow;

  ah_mul_pipelined dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (a),
    .multiplier   (b),
    .data_valid   (data_valid),
    .product      (product),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*W-1:0] p;
    logic           o;
    int unsigned    iss;
    string          name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   n_starts = 0;
  int   n_pulses = 0;

  function automatic logic [2*W-1:0] model_p(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] sx;
    logic signed [2*W-1:0] sy;
    sx = {{W{x[W-1]}}, x};
    sy = {{W{y[W-1]}}, y};
    return sx * sy;
  endfunction

  function automatic logic model_o(input logic [2*W-1:0] p);
    logic [W:0] t;
    t = p[2*W-1:W-1];
    return (t != '0) && (t != '1);
  endfunction

  task automatic send(input logic [W-1:0] ai, input logic [W-1:0] bi,
                      input logic [2*W-1:0] ep, input logic eo, input string nm);
    start = 1'b1;
    a     = ai;
    b     = bi;
    sb.push_back('{ep, eo, cyc + 1, nm});
    n_starts++;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Monitor: every data_valid pulse must match the oldest outstanding op at the right cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) begin
        n_pulses++;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: data_valid=1 with nothing outstanding, product=%h", product);
        end else begin
          e = sb.pop_front();
          if (product !== e.p || overflow !== e.o || cyc != e.iss + LAT) begin
            n_fail++;
            $display("FAIL %s: got product=%h ovf=%b at cycle %0d, expected product=%h ovf=%b at cycle %0d",
                     e.name, product, overflow, cyc, e.p, e.o, e.iss + LAT);
          end
        end
      end else if (sb.size() != 0 && cyc > sb[0].iss + LAT) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: no data_valid by cycle %0d, expected at cycle %0d", sb[0].name, cyc, sb[0].iss + LAT);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d results outstanding", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic [2*W-1:0] rp;
    int             k;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_data_valid", 128'(data_valid), 128'd0);
    chk("reset_product", product, 128'd0);
    chk("reset_overflow", 128'(overflow), 128'd0);
    rst_n = 1'b1;
    idle(2);

    // Single op, isolated so the pulse is one cycle wide.
    send(64'd7, 64'd6, 128'd42, 1'b0, "mul_7x6");
    idle(13);

    // Back-to-back with differing signs.
    send(-64'sd3, 64'd5, -128'sd15, 1'b0, "mul_m3x5");
    send(-64'sd4, -64'sd4, 128'd16, 1'b0, "mul_m4xm4");
    idle(12);

    // Boundary operands.
    send(64'h8000_0000_0000_0000, -64'sd1,
         128'h0000_0000_0000_0000_8000_0000_0000_0000, 1'b1, "min_x_m1");
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
         128'h4000_0000_0000_0000_0000_0000_0000_0000, 1'b1, "min_x_min");
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
         128'h0000_0000_0000_0000_7FFF_FFFF_FFFF_FFFF, 1'b0, "max_x_1");
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd2,
         128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFE, 1'b1, "max_x_2");
    send(64'd0, -64'sd5, 128'd0, 1'b0, "zero_x_m5");
    send(-64'sd1, -64'sd1, 128'd1, 1'b0, "m1_x_m1");
    send(64'h8000_0000_0000_0000, 64'd1,
         128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000, 1'b0, "min_x_1");
    idle(12);

    // Random stream with gaps; expected values from the reference model.
    n_starts = 0;
    n_pulses = 0;
    k = 0;
    while (k < 20) begin
      if ($urandom_range(1, 0) == 1) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        if (k % 3 == 0) rb = W'($signed($urandom_range(200, 0)) - 100);
        rp = model_p(ra, rb);
        send(ra, rb, rp, model_o(rp), $sformatf("rand_%0d", k));
        k++;
      end else begin
        idle(1);
      end
    end
    idle(14);
    chk("rand_pulse_count", 128'(n_pulses), 128'(n_starts));

    // Mid-flight reset flushes in-flight ops.
    send(64'd11, 64'd3, 128'd33, 1'b0, "flushed_0");
    send(64'd12, 64'd3, 128'd36, 1'b0, "flushed_1");
    send(64'd13, 64'd3, 128'd39, 1'b0, "flushed_2");
    idle(1);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(15);
    send(64'd9, -64'sd9, -128'sd81, 1'b0, "after_flush");
    idle(13);

    chk("scoreboard_drained", 128'(sb.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
